// File: rtl/ava_wb_mmio.sv
// Wishbone B4 pipelined slave for the AVA peripheral: register/memory window decode,
// fixed-latency in-order ack/err pipeline and an edge-triggered maskable interrupt block.
module ava_wb_mmio #(
   parameter int NUM_MEM = 2,
   parameter int MEM_AW  = 17,
   parameter int LATENCY = 1,
   parameter int NUM_IRQ = 2,
   parameter int WIN_LSB = 19
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wb_cyc,
   input  logic                      wb_stb,
   input  logic                      wb_we,
   input  logic [31:0]               wb_adr,
   input  logic [3:0]                wb_sel,
   input  logic [31:0]               wb_dat_i,
   output logic [31:0]               wb_dat_o,
   output logic                      wb_ack,
   output logic                      wb_err,
   output logic                      wb_stall,
   output logic [NUM_MEM*MEM_AW-1:0] mem_a,
   output logic [NUM_MEM*32-1:0]     mem_di,
   output logic [NUM_MEM-1:0]        mem_en,
   output logic [NUM_MEM*4-1:0]      mem_we,
   input  logic [NUM_MEM*32-1:0]     mem_do,
   input  logic [NUM_IRQ-1:0]        irq_src,
   output logic [31:0]               ctrl,
   output logic [NUM_IRQ-1:0]        irq_pend,
   output logic                      irq
);

   localparam logic [2:0] LAST_WIN = 3'(NUM_MEM);

   logic                acc;
   logic [2:0]          win;
   logic [2:0]          reg_off;
   logic                reg_wr;
   logic [31:0]         byte_mask;
   logic [31:0]         wr_val;
   logic [31:0]         rd_val;
   logic [31:0]         rdat_in;
   logic                unused_adr;

   logic [31:0]         ctrl_reg;
   logic [31:0]         scratch_reg;
   logic [NUM_IRQ-1:0]  irq_en_reg;
   logic [NUM_IRQ-1:0]  irq_pend_reg;
   logic [NUM_IRQ-1:0]  irq_src_q_reg;
   logic [NUM_IRQ-1:0]  irq_set;
   logic [NUM_IRQ-1:0]  irq_clr;
   logic [NUM_IRQ-1:0]  irq_pend_next;

   logic                pipe_valid_reg [LATENCY];
   logic [2:0]          pipe_win_reg   [LATENCY];
   logic                pipe_we_reg    [LATENCY];
   logic [31:0]         pipe_rdat_reg  [LATENCY];

   logic                out_valid;
   logic [2:0]          out_win;
   logic                out_we;
   logic                out_mapped;
   logic [31:0]         resp_dat;

   // Reset also blocks acceptance so nothing reaches the memories while it is held.
   assign acc        = wb_cyc & wb_stb & ~rst_i;
   assign win        = wb_adr[WIN_LSB+2:WIN_LSB];
   assign reg_off    = wb_adr[4:2];
   assign reg_wr     = acc & wb_we & (win == 3'd0);
   assign wr_val     = wb_dat_i & byte_mask;
   assign unused_adr = ^wb_adr;
   assign wb_stall   = 1'b0;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_mask
         assign byte_mask[gi*8 +: 8] = {8{wb_sel[gi]}};
      end
      for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_mem
         assign mem_en[gi]               = acc & (win == 3'(gi + 1));
         assign mem_a[gi*MEM_AW +: MEM_AW] = wb_adr[MEM_AW+1:2];
         assign mem_di[gi*32 +: 32]      = wb_dat_i;
         assign mem_we[gi*4 +: 4]        = (mem_en[gi] & wb_we) ? wb_sel : 4'b0000;
      end
   endgenerate

   // A rising edge in the same cycle as a write-1-to-clear keeps the bit set.
   always_comb begin
      irq_clr       = (reg_wr && reg_off == 3'd2) ? wr_val[NUM_IRQ-1:0] : '0;
      irq_set       = irq_src & ~irq_src_q_reg & irq_en_reg;
      irq_pend_next = (irq_pend_reg & ~irq_clr) | irq_set;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_reg      <= '0;
         scratch_reg   <= '0;
         irq_en_reg    <= '0;
         irq_pend_reg  <= '0;
         irq_src_q_reg <= '0;
      end else begin
         irq_src_q_reg <= irq_src;
         irq_pend_reg  <= irq_pend_next;
         if (reg_wr && reg_off == 3'd0)
            ctrl_reg <= (ctrl_reg & ~byte_mask) | wr_val;
         if (reg_wr && reg_off == 3'd1)
            irq_en_reg <= (irq_en_reg & ~byte_mask[NUM_IRQ-1:0]) | wr_val[NUM_IRQ-1:0];
         if (reg_wr && reg_off == 3'd4)
            scratch_reg <= (scratch_reg & ~byte_mask) | wr_val;
      end
   end

   always_comb begin
      rd_val = '0;
      case (reg_off)
         3'd0:    rd_val = ctrl_reg;
         3'd1:    rd_val[NUM_IRQ-1:0] = irq_en_reg;
         3'd2:    rd_val[NUM_IRQ-1:0] = irq_pend_reg;
         3'd3:    rd_val[NUM_IRQ-1:0] = irq_src;
         3'd4:    rd_val = scratch_reg;
         default: rd_val = '0;
      endcase
   end

   // Register read data is captured before this cycle's write commits.
   assign rdat_in = (win == 3'd0 && !wb_we) ? rd_val : 32'h0;

   always_ff @(posedge clk_i) begin
      if (rst_i || !wb_cyc)
         pipe_valid_reg[0] <= 1'b0;
      else
         pipe_valid_reg[0] <= acc;
      pipe_win_reg[0]  <= win;
      pipe_we_reg[0]   <= wb_we;
      pipe_rdat_reg[0] <= rdat_in;
   end

   generate
      for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
         always_ff @(posedge clk_i) begin
            if (rst_i || !wb_cyc)
               pipe_valid_reg[gi] <= 1'b0;
            else
               pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_win_reg[gi]  <= pipe_win_reg[gi-1];
            pipe_we_reg[gi]   <= pipe_we_reg[gi-1];
            pipe_rdat_reg[gi] <= pipe_rdat_reg[gi-1];
         end
      end
   endgenerate

   // Dropping wb_cyc or asserting reset suppresses the response already at the output stage.
   assign out_valid  = pipe_valid_reg[LATENCY-1] & wb_cyc & ~rst_i;
   assign out_win    = pipe_win_reg[LATENCY-1];
   assign out_we     = pipe_we_reg[LATENCY-1];
   assign out_mapped = (out_win <= LAST_WIN);
   assign wb_ack     = out_valid & out_mapped;
   assign wb_err     = out_valid & ~out_mapped;

   always_comb begin
      resp_dat = 32'h0;
      if (wb_ack && !out_we) begin
         if (out_win == 3'd0)
            resp_dat = pipe_rdat_reg[LATENCY-1];
         else
            for (int i = 0; i < NUM_MEM; i++)
               if (out_win == 3'(i + 1))
                  resp_dat = mem_do[i*32 +: 32];
      end
   end

   assign wb_dat_o = resp_dat;
   assign ctrl     = ctrl_reg;
   assign irq_pend = irq_pend_reg & irq_en_reg;
   assign irq      = |irq_pend;

endmodule

// File: tb/tb_ava_wb_mmio.sv
// Directed bench for ava_wb_mmio (LATENCY=2): responses are checked against a queue of
// expected {cycle, err, data} entries pushed as each request is driven.
module tb_ava_wb_mmio;
   localparam int NUM_MEM = 2;
   localparam int MEM_AW  = 17;
   localparam int LATENCY = 2;
   localparam int NUM_IRQ = 2;
   localparam int WIN_LSB = 19;

   logic                      clk_i = 1'b0;
   logic                      rst_i;
   logic                      wb_cyc, wb_stb, wb_we;
   logic [31:0]               wb_adr;
   logic [3:0]                wb_sel;
   logic [31:0]               wb_dat_i;
   logic [31:0]               wb_dat_o;
   logic                      wb_ack, wb_err, wb_stall;
   logic [NUM_MEM*MEM_AW-1:0] mem_a;
   logic [NUM_MEM*32-1:0]     mem_di;
   logic [NUM_MEM-1:0]        mem_en;
   logic [NUM_MEM*4-1:0]      mem_we;
   logic [NUM_MEM*32-1:0]     mem_do;
   logic [NUM_IRQ-1:0]        irq_src;
   logic [31:0]               ctrl;
   logic [NUM_IRQ-1:0]        irq_pend;
   logic                      irq;

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] dat;
   } exp_t;

   exp_t        sb[$];
   int          total_cnt = 0;
   int          pass_cnt  = 0;
   int          cyc_cnt   = 0;
   bit          mon_on    = 0;
   logic [31:0] md1 [NUM_MEM];
   logic [31:0] md2 [NUM_MEM];

   ava_wb_mmio #(
      .NUM_MEM(NUM_MEM), .MEM_AW(MEM_AW), .LATENCY(LATENCY),
      .NUM_IRQ(NUM_IRQ), .WIN_LSB(WIN_LSB)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall),
      .mem_a(mem_a), .mem_di(mem_di), .mem_en(mem_en), .mem_we(mem_we), .mem_do(mem_do),
      .irq_src(irq_src), .ctrl(ctrl), .irq_pend(irq_pend), .irq(irq)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_cnt++;

   // Memory model: read data = 0xA0000000 | window<<24 | word address, LATENCY cycles after en.
   always @(posedge clk_i) begin
      for (int w = 0; w < NUM_MEM; w++) begin
         md1[w] <= mem_en[w] ? (32'hA000_0000 | (32'(w + 1) << 24) | 32'(mem_a[w*MEM_AW +: MEM_AW]))
                             : 32'h0;
         md2[w] <= md1[w];
      end
   end
   assign mem_do = {md2[1], md2[0]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (mon_on) begin
         if (wb_ack || wb_err) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", {30'b0, wb_err, wb_ack}, 32'h0);
            end else begin
               e = sb.pop_front();
               chk("resp_cycle", cyc_cnt, e.cyc);
               chk("resp_err", {31'b0, wb_err}, {31'b0, e.err});
               chk("resp_ack", {31'b0, wb_ack}, {31'b0, ~e.err});
               chk("resp_data", wb_dat_o, e.dat);
               $display("resp cyc=%0d ack=%0b err=%0b dat=%h", cyc_cnt, wb_ack, wb_err, wb_dat_o);
            end
         end else begin
            chk("idle_data", wb_dat_o, 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input bit push, input logic err,
                      input logic [31:0] exp_dat);
      exp_t e;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
      wb_adr = adr;  wb_sel = sel;  wb_dat_i = dat;
      if (push) begin
         e.cyc = cyc_cnt + LATENCY;
         e.err = err;
         e.dat = exp_dat;
         sb.push_back(e);
      end
      $display("req cyc=%0d we=%0b adr=%h sel=%b dat=%h", cyc_cnt, we, adr, sel, dat);
      #1;
   endtask

   task automatic idle(input logic cyc);
      wb_cyc = cyc; wb_stb = 1'b0; wb_we = 1'b0;
      tick();
   endtask

   initial begin
      rst_i = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      wb_adr = '0; wb_sel = '0; wb_dat_i = '0; irq_src = '0;
      repeat (3) tick();
      rst_i = 1'b0;
      chk("rst_ctrl", ctrl, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_ack", {30'b0, wb_err, wb_ack}, 32'h0);
      chk("rst_mem_en", {30'b0, mem_en}, 32'h0);
      mon_on = 1;

      // CTRL write then read-back
      req(1'b1, 32'h0, 4'b0001, 32'h0000_00A5, 1, 1'b0, 32'h0); tick();
      req(1'b0, 32'h0, 4'b1111, 32'h0, 1, 1'b0, 32'h0000_00A5); tick();
      idle(1'b1); idle(1'b1);
      chk("ctrl_a5", ctrl, 32'h0000_00A5);

      // Back-to-back: window1, window2, IRQ_RAW
      req(1'b0, 32'h0008_0004, 4'b1111, 32'h0, 1, 1'b0, 32'hA100_0001);
      chk("w1_en", {30'b0, mem_en}, 32'h1);
      chk("w1_a", {15'b0, mem_a[MEM_AW-1:0]}, 32'h1);
      tick();
      req(1'b0, 32'h0010_0008, 4'b1111, 32'h0, 1, 1'b0, 32'hA200_0002);
      chk("w2_en", {30'b0, mem_en}, 32'h2);
      chk("w2_a", {15'b0, mem_a[2*MEM_AW-1:MEM_AW]}, 32'h2);
      tick();
      irq_src = 2'b10;
      req(1'b0, 32'h0000_000C, 4'b1111, 32'h0, 1, 1'b0, 32'h2); tick();
      idle(1'b1); idle(1'b1); idle(1'b1);
      irq_src = 2'b00;
      chk("raw_no_pend", {30'b0, irq_pend}, 32'h0);

      // Memory write with partial byte enables
      req(1'b1, 32'h0008_0010, 4'b0110, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
      chk("mw_we", {24'b0, mem_we}, 32'h06);
      chk("mw_di", mem_di[31:0], 32'hDEAD_BEEF);
      chk("mw_a", {15'b0, mem_a[MEM_AW-1:0]}, 32'h4);
      tick();
      idle(1'b1);

      // Unmapped windows 7 and 3
      req(1'b0, 32'h0038_0000, 4'b1111, 32'h0, 1, 1'b1, 32'h0);
      chk("w7_en", {30'b0, mem_en}, 32'h0);
      tick();
      req(1'b1, 32'h0018_0000, 4'b1111, 32'h1234, 1, 1'b1, 32'h0);
      chk("w3_we", {24'b0, mem_we}, 32'h0);
      tick();
      idle(1'b1); idle(1'b1);

      // Interrupts
      req(1'b1, 32'h4, 4'b1111, 32'h1, 1, 1'b0, 32'h0); tick();
      idle(1'b1);
      irq_src = 2'b11; idle(1'b1);
      irq_src = 2'b00;
      chk("pend_set", {30'b0, irq_pend}, 32'h1);
      chk("irq_set", {31'b0, irq}, 32'h1);
      req(1'b0, 32'h8, 4'b1111, 32'h0, 1, 1'b0, 32'h1); tick();
      irq_src = 2'b01;
      req(1'b1, 32'h8, 4'b1111, 32'h1, 1, 1'b0, 32'h0); tick();
      chk("set_wins_pend", {30'b0, irq_pend}, 32'h1);
      chk("set_wins_irq", {31'b0, irq}, 32'h1);
      req(1'b1, 32'h8, 4'b1111, 32'h1, 1, 1'b0, 32'h0); tick();
      chk("w1c_pend", {30'b0, irq_pend}, 32'h0);
      chk("w1c_irq", {31'b0, irq}, 32'h0);
      irq_src = 2'b00;
      idle(1'b1); idle(1'b1);

      // wb_cyc drop flushes in-flight requests
      req(1'b0, 32'h0008_0004, 4'b1111, 32'h0, 1, 1'b0, 32'hA100_0001); tick();
      req(1'b0, 32'h0008_0008, 4'b1111, 32'h0, 0, 1'b0, 32'h0); tick();
      req(1'b0, 32'h0008_000C, 4'b1111, 32'h0, 0, 1'b0, 32'h0); tick();
      idle(1'b0);
      req(1'b0, 32'h0, 4'b1111, 32'h0, 1, 1'b0, 32'h0000_00A5); tick();
      idle(1'b1); idle(1'b1); idle(1'b1);

      // Reset with requests in flight
      req(1'b1, 32'h0, 4'b1111, 32'h0000_00FF, 1, 1'b0, 32'h0); tick();
      idle(1'b1); idle(1'b1);
      chk("ctrl_ff", ctrl, 32'h0000_00FF);
      irq_src = 2'b01; idle(1'b1);
      irq_src = 2'b00;
      chk("irq_before_rst", {31'b0, irq}, 32'h1);
      req(1'b0, 32'h0, 4'b1111, 32'h0, 0, 1'b0, 32'h0); tick();
      req(1'b0, 32'h0010_0000, 4'b1111, 32'h0, 0, 1'b0, 32'h0); tick();
      rst_i = 1'b1;
      idle(1'b1);
      rst_i = 1'b0;
      chk("midrst_ctrl", ctrl, 32'h0);
      chk("midrst_irq", {31'b0, irq}, 32'h0);
      chk("midrst_pend", {30'b0, irq_pend}, 32'h0);
      chk("midrst_ack", {30'b0, wb_err, wb_ack}, 32'h0);
      idle(1'b1); idle(1'b1); idle(1'b1);

      chk("sb_empty", sb.size(), 32'h0);
      idle(1'b0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
